bytepad_stream_ctrl: RTL and testbench

Byte-serial controller that produces the NIST SP 800-185 `bytepad(X, w)` stream for the KMAC front end: `left_encode(w) || X || 0x00...` to a multiple of `w` bytes. It takes a start command with the length of X, pulls X byte-by-byte from an upstream source, and feeds the Keccak absorber through a valid/ready stream. It also flags every rate-block boundary so the absorber knows when to permute. This block sequences the padding datapath; it holds no message buffer.

---
 rtl/bytepad_stream_ctrl_if.sv | 21 ++
 rtl/bytepad_stream_ctrl.sv | 143 ++++++++++++++
 tb/tb_bytepad_stream_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bytepad_stream_ctrl_if.sv
// rtl/bytepad_stream_ctrl_if.sv - byte streams between X source, bytepad controller and absorber
interface bytepad_stream_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       block_last;
    logic       out_last;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, block_last, out_last
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, block_last, out_last
    );
endinterface

// File: rtl/bytepad_stream_ctrl.sv
// rtl/bytepad_stream_ctrl.sv - bytepad(X, w) sequencer feeding the Keccak absorber byte stream
module bytepad_stream_ctrl #(
    parameter  int W_BYTES = 136,
    parameter  int MAX_LEN = 32,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LW-1:0]         msg_len,
    bytepad_stream_ctrl_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  len_err
);
    localparam int             BW     = $clog2(W_BYTES);
    localparam logic [BW-1:0]  B_LAST = BW'(W_BYTES - 1);
    localparam logic [LW-1:0]  L_MAX  = LW'(MAX_LEN);
    localparam logic [7:0]     W8     = 8'(W_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_PAD,
        S_DONE
    } state_t;

    state_t        state;
    logic [BW-1:0] bcnt;
    logic [LW-1:0] pcnt;
    logic [LW-1:0] len_q;

    logic          xfer;
    logic          blk_end;
    logic [LW-1:0] pcnt_next;
    logic          last_data;
    logic          final_byte;

    // DATA is a pure pass-through so the source sees the absorber's backpressure directly.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        case (state)
            S_HDR0: begin
                bus.out_valid = 1'b1;
                bus.out_data  = 8'h01;
            end
            S_HDR1: begin
                bus.out_valid = 1'b1;
                bus.out_data  = W8;
            end
            S_DATA: begin
                bus.out_valid = bus.in_valid;
                bus.out_data  = bus.in_valid ? bus.in_data : 8'h00;
                bus.in_ready  = bus.out_ready;
            end
            S_PAD: begin
                bus.out_valid = 1'b1;
            end
            default: begin
                bus.out_valid = 1'b0;
            end
        endcase
    end

    assign xfer      = bus.out_valid && bus.out_ready;
    assign blk_end   = (bcnt == B_LAST);
    assign pcnt_next = pcnt + LW'(1);
    assign last_data = (pcnt_next == len_q);

    // The stream ends on the first block boundary reached once all of X has been sent.
    always_comb begin
        final_byte = 1'b0;
        case (state)
            S_HDR1:  final_byte = (len_q == '0) && blk_end;
            S_DATA:  final_byte = last_data && blk_end;
            S_PAD:   final_byte = blk_end;
            default: final_byte = 1'b0;
        endcase
    end

    assign bus.block_last = bus.out_valid && blk_end;
    assign bus.out_last   = bus.out_valid && final_byte;
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bcnt    <= '0;
            pcnt    <= '0;
            len_q   <= '0;
            len_err <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (xfer) begin
                bcnt <= blk_end ? '0 : bcnt + BW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (msg_len > L_MAX) begin
                            len_err <= 1'b1;
                        end else begin
                            len_q <= msg_len;
                            bcnt  <= '0;
                            pcnt  <= '0;
                            state <= S_HDR0;
                        end
                    end
                end
                S_HDR0: begin
                    if (xfer) state <= S_HDR1;
                end
                S_HDR1: begin
                    if (xfer) begin
                        if (len_q != '0)  state <= S_DATA;
                        else if (blk_end) state <= S_DONE;
                        else              state <= S_PAD;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        pcnt <= pcnt_next;
                        if (last_data) state <= blk_end ? S_DONE : S_PAD;
                    end
                end
                S_PAD: begin
                    if (xfer && blk_end) state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bytepad_stream_ctrl.sv
// tb/tb_bytepad_stream_ctrl.sv - directed bench for bytepad_stream_ctrl with W_BYTES=8, MAX_LEN=16
module tb_bytepad_stream_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] msg_len;
    logic       busy;
    logic       done;
    logic       len_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] xmem [0:15];

    bytepad_stream_ctrl_if bus ();

    bytepad_stream_ctrl #(
        .W_BYTES(8),
        .MAX_LEN(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .msg_len(msg_len),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int len, input int i);
        if (i == 0)           return 8'h01;
        else if (i == 1)      return 8'h08;
        else if (i < len + 2) return xmem[i-2];
        else                  return 8'h00;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"},  bus.out_valid,  1'b0);
        check({tag, "_out_data"},   bus.out_data,   8'h00);
        check({tag, "_in_ready"},   bus.in_ready,   1'b0);
        check({tag, "_block_last"}, bus.block_last, 1'b0);
        check({tag, "_out_last"},   bus.out_last,   1'b0);
        check({tag, "_busy"},       busy,           1'b0);
        check({tag, "_done"},       done,           1'b0);
        check({tag, "_len_err"},    len_err,        1'b0);
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the next free IDLE cycle.
    task automatic run_stream(input int len, input bit stall, input int abort_at);
        int  total;
        int  oidx;
        int  src;
        int  cyc;
        bit  iv;
        bit  ir_bad;
        bit  aborted;
        total   = ((len + 2 + 7) / 8) * 8;
        oidx    = 0;
        src     = 0;
        cyc     = 0;
        ir_bad  = 1'b0;
        aborted = 1'b0;
        start   = 1'b1;
        msg_len = 5'(len);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("first_byte_valid", bus.out_valid, 1'b1);
        check("first_byte_data", bus.out_data, 8'h01);
        while (oidx < total && cyc < 1000) begin
            if (abort_at >= 0 && oidx == abort_at) begin
                rst     = 1'b1;
                aborted = 1'b1;
                break;
            end
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            iv = (src < len) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            bus.in_valid = iv;
            bus.in_data  = iv ? xmem[src] : 8'h00;
            start   = stall && (cyc == 5);
            msg_len = 5'd20;
            @(negedge clk);
            if (bus.in_ready && src >= len) ir_bad = 1'b1;
            if (stall && cyc == 6) begin
                check("busy_start_no_len_err", len_err, 1'b0);
                check("busy_start_still_busy", busy, 1'b1);
            end
            if (bus.out_valid) begin
                check($sformatf("data[%0d]", oidx), bus.out_data, exp_byte(len, oidx));
                if (bus.out_ready) begin
                    check($sformatf("block_last[%0d]", oidx), bus.block_last, (oidx % 8) == 7);
                    check($sformatf("out_last[%0d]", oidx), bus.out_last, oidx == total - 1);
                    oidx++;
                end
            end
            if (bus.in_valid && bus.in_ready) src++;
            @(posedge clk);
            #1;
            cyc++;
        end
        start        = 1'b0;
        msg_len      = 5'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.out_ready = 1'b1;
        if (aborted) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_idle_outputs("after_rst");
            @(posedge clk);
            #1;
            rst = 1'b0;
        end else begin
            check("stream_length", oidx, total);
            check("bytes_consumed", src, len);
            check("in_ready_after_x", ir_bad, 1'b0);
            @(negedge clk);
            check("done_pulse", done, 1'b1);
            check("busy_in_done", busy, 1'b1);
            check("no_valid_in_done", bus.out_valid, 1'b0);
            @(negedge clk);
            check("done_cleared", done, 1'b0);
            check("busy_cleared", busy, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        msg_len       = 5'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) xmem[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 3; i++) xmem[i] = 8'hAA + 8'(8'h11 * i);
        run_stream(3, 1'b0, -1);

        for (int i = 0; i < 6; i++) xmem[i] = 8'(8'h11 * (i + 1));
        run_stream(6, 1'b0, -1);

        for (int i = 0; i < 7; i++) xmem[i] = 8'hA1 + 8'(i);
        run_stream(7, 1'b0, -1);

        run_stream(0, 1'b0, -1);

        for (int i = 0; i < 16; i++) xmem[i] = 8'h30 + 8'(i);
        run_stream(16, 1'b0, -1);

        for (int i = 0; i < 3; i++) xmem[i] = 8'hAA + 8'(8'h11 * i);
        run_stream(3, 1'b1, -1);

        start   = 1'b1;
        msg_len = 5'd17;
        @(posedge clk);
        #1;
        start   = 1'b0;
        msg_len = 5'd0;
        @(negedge clk);
        check("len_err_pulse", len_err, 1'b1);
        check("len_err_not_busy", busy, 1'b0);
        check("len_err_no_output", bus.out_valid, 1'b0);
        @(negedge clk);
        check("len_err_cleared", len_err, 1'b0);
        check("len_err_still_idle", busy, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) xmem[i] = 8'hC0 + 8'(i);
        run_stream(5, 1'b0, 3);

        for (int i = 0; i < 3; i++) xmem[i] = 8'hAA + 8'(8'h11 * i);
        run_stream(3, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
